fpu_sp_seq_multiplier: RTL and testbench
========================================

Name: fpu_sp_seq_multiplier

Overview:
- Sequential IEEE-754 single-precision multiplier: result = A * B, computed by a 24-iteration shift-add mantissa datapath.
- Functional inverse of the divider datapath. Small-area alternative to the combinational multiplier for the FPU's multi-cycle issue path.
- Valid/ready handshake on input and output. One operation in flight.

Parameters:
- WIDTH, 32, operand/result width; only 32 supported.
- MANT_W, 24, mantissa width including hidden bit; sets iteration count.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands A/B present
- in_ready  output  1  block can accept operands
- A  input  WIDTH  multiplicand, IEEE-754 single
- B  input  WIDTH  multiplier, IEEE-754 single
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  product
- overflow  output  1  exponent overflow, result forced to ±inf
- underflow  output  1  exponent underflow, result flushed to ±0

Behaviour:
- Reset: one clock (clk); asynchronous active-low reset (rst_n).
  - Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, overflow=0, underflow=0.
  - Assertion mid-operation aborts immediately with no partial output.
- Accept: in_valid & in_ready on a clk edge latches A and B. in_ready=1 only in IDLE.
- FSM:
  - IDLE -> UNPACK on accept.
  - UNPACK -> SPECIAL if either operand is zero/denormal/inf/NaN; otherwise MULT.
  - MULT: 24 cycles, counter 0..23; each cycle adds (multiplicand << i) into a 48-bit accumulator when multiplier bit i=1. Then -> NORM.
  - NORM -> DONE.
  - SPECIAL -> DONE.
  - DONE: out_valid=1; stays until out_ready, then -> IDLE.
- Latency, counting the accept edge as cycle 0:
  - Normal path: out_valid rises at cycle 27.
  - Special path: out_valid rises at cycle 2.
  - Next accept is possible on the cycle after the out handshake.
- Backpressure: result, overflow and underflow stay stable while out_valid & !out_ready.
- Sign = A[31] ^ B[31] in every case, including zero and inf results.
- Exponent: 10-bit signed e = eA + eB - 127.
  - Product bit 47 set: shift right 1, e+1. Otherwise use bits 46:23.
  - Post-round mantissa carry-out: shift right 1, e+1.
  - e >= 255: result = {sign, 0xFF, 0}, overflow=1.
  - e <= 0: result = {sign, 0x00, 0}, underflow=1.
- Special cases (denormal inputs treated as zero):
  - NaN operand, or inf * zero -> 0x7FC00000, flags 0.
  - inf * finite nonzero -> ±inf, flags 0.
  - zero * finite -> ±0, flags 0.
- Flags are meaningful only while out_valid=1. They clear on leaving DONE.
- in_valid while busy is ignored; the source must hold it.

Optional Feature:
- Macro: FPU_SEQ_MUL_RNE_EN.
- Defined: round-to-nearest-even using guard, round and sticky bits from the discarded accumulator bits.
- Undefined: truncation (round toward zero). Guard/sticky logic is not built. Latency is identical in both builds.

Test Plan:
- Basic product and latency: A=0x40000000 (2.0), B=0x40400000 (3.0) -> result 0x40C00000, flags 0, out_valid exactly 27 cycles after accept.
- Normalization path: A=B=0x3FC00000 (1.5) -> 0x40100000 (2.25).
- Rounding: A=B=0x3FC00001 -> 0x40100002 with FPU_SEQ_MUL_RNE_EN, 0x40100001 without.
- Overflow and underflow:
  - A=0x7F000000, B=0x40000000 -> 0x7F800000, overflow=1.
  - A=0x00800000, B=0x3F000000 -> 0x00000000, underflow=1.
- Specials: A=0x7F800000, B=0x00000000 -> 0x7FC00000 at cycle 2; A=0xC0000000, B=0x00000000 -> 0x80000000 at cycle 2.
- Handshake and reset:
  - out_ready held low 5 cycles in DONE -> result stable, in_ready=0.
  - rst_n pulsed low at MULT cycle 10 -> out_valid=0, in_ready=1 immediately.
  - Next op 0x3F800000*0x3F800000 -> 0x3F800000.

Source files
------------

// File: rtl/fpu_sp_seq_multiplier.sv
// Sequential IEEE-754 single-precision multiplier built on a 24-step shift-add mantissa datapath.
// Optional macro FPU_SEQ_MUL_RNE_EN selects round-to-nearest-even; otherwise the product is truncated.
module fpu_sp_seq_multiplier #(
    parameter int WIDTH  = 32,
    parameter int MANT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             underflow
);
    localparam int ACC_W = 2 * MANT_W;

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_MULT, S_NORM, S_SPECIAL, S_DONE
    } state_t;

    state_t              r_state, w_next;
    logic [31:0]         r_a, r_b;
    logic [4:0]          r_cnt;
    logic [MANT_W-1:0]   r_mcand, r_mplier, r_mant;
    logic [ACC_W-1:0]    r_acc;
    logic signed [9:0]   r_exp;
    logic                r_sign, r_norm_phase;
    logic [31:0]         r_result;
    logic                r_ovf, r_udf;

    // Operand classification; denormals are folded into zero.
    logic w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan, w_special;
    assign w_a_zero  = (r_a[30:23] == 8'h00);
    assign w_a_inf   = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
    assign w_a_nan   = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
    assign w_b_zero  = (r_b[30:23] == 8'h00);
    assign w_b_inf   = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
    assign w_b_nan   = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
    assign w_special = w_a_zero | w_a_inf | w_a_nan | w_b_zero | w_b_inf | w_b_nan;

    // Normalisation reads the finished accumulator; rounding runs one cycle later
    // from registered values so the two adders never chain in one cycle.
    logic                w_p47;
    logic [MANT_W-1:0]   w_norm_mant;
    logic signed [9:0]   w_norm_exp;
    assign w_p47       = r_acc[ACC_W-1];
    assign w_norm_mant = w_p47 ? r_acc[47:24] : r_acc[46:23];
    assign w_norm_exp  = r_exp + (w_p47 ? 10'sd1 : 10'sd0);

    logic w_round_up;
`ifdef FPU_SEQ_MUL_RNE_EN
    logic r_grd, r_stk, w_grd, w_stk;
    assign w_grd      = w_p47 ? r_acc[23] : r_acc[22];
    assign w_stk      = w_p47 ? (|r_acc[22:0]) : (|r_acc[21:0]);
    assign w_round_up = r_grd & (r_stk | r_mant[0]);
`else
    logic w_unused_low;
    assign w_unused_low = ^r_acc[22:0];
    assign w_round_up   = 1'b0;
`endif

    logic [MANT_W:0]   w_rounded;
    logic [22:0]       w_frac;
    logic signed [9:0] w_final_exp;
    logic              w_ovf, w_udf;
    assign w_rounded   = {1'b0, r_mant} + {{MANT_W{1'b0}}, w_round_up};
    assign w_frac      = w_rounded[MANT_W] ? w_rounded[23:1] : w_rounded[22:0];
    assign w_final_exp = r_exp + $signed({9'd0, w_rounded[MANT_W]});
    assign w_ovf       = (w_final_exp >= 10'sd255);
    assign w_udf       = (w_final_exp <= 10'sd0);

    // NOTE: every sequential block uses non-blocking assignments so all registers
    // update together on the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: w_next takes its hold value first so no path through the case leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (in_valid) w_next = S_UNPACK;
            S_UNPACK:  w_next = w_special ? S_SPECIAL : S_MULT;
            S_MULT:    if (r_cnt == 5'(MANT_W - 1)) w_next = S_NORM;
            S_NORM:    if (r_norm_phase) w_next = S_DONE;
            S_SPECIAL: w_next = S_DONE;
            S_DONE:    if (out_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;  r_b <= '0;  r_cnt <= '0;  r_acc <= '0;
            r_mcand <= '0;  r_mplier <= '0;  r_mant <= '0;
            r_exp <= '0;  r_sign <= 1'b0;  r_norm_phase <= 1'b0;
            r_result <= '0;  r_ovf <= 1'b0;  r_udf <= 1'b0;
`ifdef FPU_SEQ_MUL_RNE_EN
            r_grd <= 1'b0;  r_stk <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_a <= A;
                    r_b <= B;
                end
                S_UNPACK: begin
                    r_sign   <= r_a[31] ^ r_b[31];
                    r_exp    <= $signed({2'b00, r_a[30:23]}) + $signed({2'b00, r_b[30:23]}) - 10'sd127;
                    r_mcand  <= {1'b1, r_a[22:0]};
                    r_mplier <= {1'b1, r_b[22:0]};
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end
                S_MULT: begin
                    if (r_mplier[r_cnt])
                        r_acc <= r_acc + ({{MANT_W{1'b0}}, r_mcand} << r_cnt);
                    r_cnt <= r_cnt + 5'd1;
                end
                S_NORM: begin
                    if (!r_norm_phase) begin
                        r_mant <= w_norm_mant;
                        r_exp  <= w_norm_exp;
`ifdef FPU_SEQ_MUL_RNE_EN
                        r_grd  <= w_grd;
                        r_stk  <= w_stk;
`endif
                        r_norm_phase <= 1'b1;
                    end else begin
                        r_norm_phase <= 1'b0;
                        r_ovf <= w_ovf;
                        r_udf <= w_udf && !w_ovf;
                        if (w_ovf)      r_result <= {r_sign, 8'hFF, 23'd0};
                        else if (w_udf) r_result <= {r_sign, 8'h00, 23'd0};
                        else            r_result <= {r_sign, w_final_exp[7:0], w_frac};
                    end
                end
                S_SPECIAL: begin
                    r_ovf <= 1'b0;
                    r_udf <= 1'b0;
                    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
                        r_result <= 32'h7FC0_0000;
                    else if (w_a_inf || w_b_inf)
                        r_result <= {r_a[31] ^ r_b[31], 8'hFF, 23'd0};
                    else
                        r_result <= {r_a[31] ^ r_b[31], 8'h00, 23'd0};
                end
                S_DONE: if (out_ready) begin
                    r_result <= '0;
                    r_ovf    <= 1'b0;
                    r_udf    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign overflow  = r_ovf;
    assign underflow = r_udf;

endmodule

// File: tb/tb_fpu_sp_seq_multiplier.sv
// Scoreboard bench for fpu_sp_seq_multiplier: driver queues hand-computed results,
// an output monitor pops and compares them, including latency and backpressure stability.
module tb_fpu_sp_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, result;
    logic        overflow, underflow;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        udf;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   stall_n  = 0;

`ifdef FPU_SEQ_MUL_RNE_EN
    localparam logic [31:0] RND_EXP = 32'h4010_0002;
`else
    localparam logic [31:0] RND_EXP = 32'h4010_0001;
`endif

    fpu_sp_seq_multiplier dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                         input logic ovf, input logic udf, input int lat);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.res = res; e.ovf = ovf; e.udf = udf; e.lat = lat; e.acc_cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Output monitor: compares on the first cycle of each out_valid pulse.
    initial begin
        exp_t        e;
        logic [31:0] held;
        logic        seen = 1'b0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                    check("underflow", {31'd0, underflow}, {31'd0, e.udf});
                    check("latency", cyc - e.acc_cyc, e.lat);
                end
                if (stall_n > 0) begin
                    out_ready = 1'b0;
                    held = result;
                    for (int k = 0; k < stall_n; k++) begin
                        @(negedge clk);
                        check("stall_result", result, held);
                        check("stall_valid", {31'd0, out_valid}, 32'd1);
                        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    end
                    stall_n = 0;
                    out_ready = 1'b1;
                end
            end else if (!out_valid && seen) begin
                seen = 1'b0;
                check("flags_cleared", {30'd0, overflow, underflow}, 32'd0);
            end
        end
    end

    initial begin
        int waited;
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        rst_n = 1'b1;

        issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, 27);
        stall_n = 5;
        issue(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0, 27);
        issue(32'h3FC0_0001, 32'h3FC0_0001, RND_EXP,       1'b0, 1'b0, 27);
        issue(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1, 1'b0, 27);
        issue(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 27);
        issue(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0, 2);
        issue(32'hC000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 2);
        issue(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, 2);
        issue(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 1'b0, 1'b0, 2);

        // Abort an operation partway through the shift-add loop.
        issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, 27);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_result", result, 32'd0);
        if (sb.size() > 0) void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 27);

        waited = 0;
        while ((sb.size() != 0 || out_valid) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
